memory_stage: RTL and testbench

- MEM and WB stages of the 32-bit MIPS pipeline, downstream of the execute stage.
- Captures the execute stage's outputs in the EX/MEM register and accesses the data memory (byte-enabled, synchronous read).
- Captures loaded or ALU data in the MEM/WB register and drives the writeback value.
- Returns the forwarding sources (EX/MEM ALU result, WB data, destination regs, regWrite flags) to the execute stage, and resolves branches (PCSrc).

---
 rtl/mem_pkg.sv | 49 ++++
 rtl/data_memory.sv | 33 +++
 rtl/memory_stage.sv | 139 +++++++++++++
 tb/tb_memory_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - access-size encodings and lane helpers for the MEM/WB stages
package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] be;
    case (size)
      MEM_BYTE: be = 4'b0001 << offset;
      MEM_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate narrow store data across lanes so the byte enables pick the right copy.
  function automatic logic [31:0] storeData(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] d;
    case (size)
      MEM_BYTE: d = {4{data[7:0]}};
      MEM_HALF: d = {2{data[15:0]}};
      default:  d = data;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] loadExtend(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] offset, input logic isUnsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (offset)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_BYTE: r = isUnsigned ? {24'b0, b} : {{24{b[7]}}, b};
      MEM_HALF: r = isUnsigned ? {16'b0, h} : {{16{h[15]}}, h};
      default:  r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - byte-enabled data RAM, synchronous write-first read
module data_memory #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_enable,
  input  logic [3:0]        i_byteEn,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] merged;

  always_comb begin
    merged = mem[i_addr];
    for (int b = 0; b < 4; b++) begin
      if (i_byteEn[b]) merged[b*8 +: 8] = i_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_enable) begin
      for (int b = 0; b < 4; b++) begin
        if (i_byteEn[b]) mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
      o_rdata <= merged;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MIPS MEM/WB stages; MEM_ALIGN_CHECK_EN adds misalignment trapping
module memory_stage
  import mem_pkg::*;
#(
  parameter int N_BITS     = 32,
  parameter int N_BITS_REG = 6,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_W     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic [N_BITS-1:0]     i_aluResult,
  input  logic [N_BITS-1:0]     i_datoLeido2,
  input  logic [N_BITS_REG-1:0] i_rd,
  input  logic                  i_ceroSignal,
  input  logic [N_BITS-1:0]     i_branchTarget,
  input  logic                  i_branch,
  input  logic                  i_memRead,
  input  logic                  i_memWrite,
  input  logic                  i_memToReg,
  input  logic                  i_regWrite,
  input  logic [1:0]            i_memSize,
  input  logic                  i_memUnsigned,
  output logic                  o_pcSrc,
  output logic [N_BITS-1:0]     o_branchTarget,
  output logic [N_BITS-1:0]     o_memData,
  output logic [N_BITS_REG-1:0] o_rd_EX_MEM,
  output logic                  o_regWrite_EX_MEM,
  output logic [N_BITS-1:0]     o_wbData,
  output logic [N_BITS_REG-1:0] o_rd_MEM_WB,
  output logic                  o_regWrite_MEM_WB
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                  o_misaligned
`endif
);

  logic [N_BITS-1:0]     exmemAlu, exmemData, exmemTarget;
  logic [N_BITS_REG-1:0] exmemRd;
  logic                  exmemCero, exmemBranch, exmemMemRead, exmemMemWrite;
  logic                  exmemMemToReg, exmemRegWrite, exmemUnsigned;
  logic [1:0]            exmemSize;

  logic [N_BITS-1:0]     memwbAlu;
  logic [N_BITS_REG-1:0] memwbRd;
  logic                  memwbRegWrite, memwbMemToReg, memwbUnsigned;
  logic [1:0]            memwbSize, memwbOffset;

  logic [N_BITS-1:0]     readData;
  logic [3:0]            byteEn;
  logic                  misaligned;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      exmemAlu      <= '0;
      exmemData     <= '0;
      exmemTarget   <= '0;
      exmemRd       <= '0;
      exmemCero     <= 1'b0;
      exmemBranch   <= 1'b0;
      exmemMemRead  <= 1'b0;
      exmemMemWrite <= 1'b0;
      exmemMemToReg <= 1'b0;
      exmemRegWrite <= 1'b0;
      exmemSize     <= '0;
      exmemUnsigned <= 1'b0;
    end else if (i_enable) begin
      exmemAlu      <= i_aluResult;
      exmemData     <= i_datoLeido2;
      exmemTarget   <= i_branchTarget;
      exmemRd       <= i_rd;
      exmemCero     <= i_ceroSignal;
      exmemBranch   <= i_branch & ~i_flush;
      exmemMemRead  <= i_memRead & ~i_flush;
      exmemMemWrite <= i_memWrite & ~i_flush;
      exmemMemToReg <= i_memToReg;
      exmemRegWrite <= i_regWrite & ~i_flush;
      exmemSize     <= i_memSize;
      exmemUnsigned <= i_memUnsigned;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (exmemMemRead | exmemMemWrite) &
                      (((exmemSize == MEM_HALF) & exmemAlu[0]) |
                       ((exmemSize == MEM_WORD) & (|exmemAlu[1:0])));
  assign o_misaligned = misaligned;
`else
  assign misaligned = 1'b0;
`endif

  assign byteEn = byteEnable(exmemSize, exmemAlu[1:0]) & {4{exmemMemWrite & ~misaligned}};

  // The RAM only clocks on memory ops, so readData keeps the last loaded word otherwise.
  data_memory #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_dataMemory (
    .i_clk   (i_clk),
    .i_enable(i_enable & (exmemMemRead | exmemMemWrite)),
    .i_byteEn(byteEn),
    .i_addr  (exmemAlu[ADDR_W+1:2]),
    .i_wdata (storeData(exmemSize, exmemData)),
    .o_rdata (readData)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      memwbAlu      <= '0;
      memwbRd       <= '0;
      memwbRegWrite <= 1'b0;
      memwbMemToReg <= 1'b0;
      memwbSize     <= '0;
      memwbUnsigned <= 1'b0;
      memwbOffset   <= '0;
    end else if (i_enable) begin
      memwbAlu      <= exmemAlu;
      memwbRd       <= exmemRd;
      memwbRegWrite <= exmemRegWrite & ~misaligned;
      memwbMemToReg <= exmemMemToReg;
      memwbSize     <= exmemSize;
      memwbUnsigned <= exmemUnsigned;
      memwbOffset   <= exmemAlu[1:0];
    end
  end

  assign o_pcSrc           = exmemBranch & exmemCero;
  assign o_branchTarget    = exmemTarget;
  assign o_memData         = exmemAlu;
  assign o_rd_EX_MEM       = exmemRd;
  assign o_regWrite_EX_MEM = exmemRegWrite;
  assign o_wbData          = memwbMemToReg ? loadExtend(readData, memwbSize, memwbOffset, memwbUnsigned)
                                           : memwbAlu;
  assign o_rd_MEM_WB       = memwbRd;
  assign o_regWrite_MEM_WB = memwbRegWrite;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - scoreboard bench for memory_stage (MEM_ALIGN_CHECK_EN optional)
module tb_memory_stage;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic        i_clk = 1'b0;
  logic        i_reset, i_enable, i_flush;
  logic [31:0] i_aluResult, i_datoLeido2, i_branchTarget;
  logic [5:0]  i_rd;
  logic        i_ceroSignal, i_branch, i_memRead, i_memWrite, i_memToReg, i_regWrite;
  logic [1:0]  i_memSize;
  logic        i_memUnsigned;
  logic        o_pcSrc, o_regWrite_EX_MEM, o_regWrite_MEM_WB;
  logic [31:0] o_branchTarget, o_memData, o_wbData;
  logic [5:0]  o_rd_EX_MEM, o_rd_MEM_WB;
`ifdef MEM_ALIGN_CHECK_EN
  logic        o_misaligned;
`endif

  memory_stage dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
    .i_aluResult(i_aluResult), .i_datoLeido2(i_datoLeido2), .i_rd(i_rd),
    .i_ceroSignal(i_ceroSignal), .i_branchTarget(i_branchTarget), .i_branch(i_branch),
    .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_memToReg(i_memToReg),
    .i_regWrite(i_regWrite), .i_memSize(i_memSize), .i_memUnsigned(i_memUnsigned),
    .o_pcSrc(o_pcSrc), .o_branchTarget(o_branchTarget), .o_memData(o_memData),
    .o_rd_EX_MEM(o_rd_EX_MEM), .o_regWrite_EX_MEM(o_regWrite_EX_MEM),
    .o_wbData(o_wbData), .o_rd_MEM_WB(o_rd_MEM_WB), .o_regWrite_MEM_WB(o_regWrite_MEM_WB)
`ifdef MEM_ALIGN_CHECK_EN
    , .o_misaligned(o_misaligned)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  rd;
  } wbExp_t;

  wbExp_t sbQ[$];
  int     compared   = 0;
  int     mismatched = 0;
  logic   wbLoaded   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // A writeback happened on an edge only if the pipeline advanced out of reset.
  always @(posedge i_clk) wbLoaded <= i_enable && i_reset;

  always @(negedge i_clk) begin
    if (wbLoaded && o_regWrite_MEM_WB) begin
      if (sbQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_wb: got rd %0d data 0x%08h expected none", o_rd_MEM_WB, o_wbData);
      end else begin
        wbExp_t e;
        e = sbQ.pop_front();
        check("wbData", o_wbData, e.data);
        check("wbRd", {26'b0, o_rd_MEM_WB}, {26'b0, e.rd});
      end
    end
  end

  task automatic clearInputs();
    i_flush = 0; i_aluResult = 0; i_datoLeido2 = 0; i_rd = 0; i_ceroSignal = 0;
    i_branchTarget = 0; i_branch = 0; i_memRead = 0; i_memWrite = 0; i_memToReg = 0;
    i_regWrite = 0; i_memSize = SZ_W; i_memUnsigned = 0;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic nop();
    clearInputs();
    step();
  endtask

  task automatic doStore(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    clearInputs();
    i_aluResult = addr; i_datoLeido2 = data; i_memWrite = 1; i_memSize = size;
    step();
  endtask

  task automatic doLoad(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                        input logic [5:0] rd, input logic [31:0] exp);
    clearInputs();
    i_aluResult = addr; i_memRead = 1; i_memToReg = 1; i_regWrite = 1;
    i_memSize = size; i_memUnsigned = uns; i_rd = rd;
    sbQ.push_back('{data: exp, rd: rd});
    step();
  endtask

  task automatic doAlu(input logic [31:0] val, input logic [5:0] rd);
    clearInputs();
    i_aluResult = val; i_regWrite = 1; i_rd = rd;
    sbQ.push_back('{data: val, rd: rd});
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clearInputs();
    i_reset = 0; i_enable = 1;
    repeat (2) step();
    check("rst_wbData", o_wbData, 32'h0);
    check("rst_memData", o_memData, 32'h0);
    check("rst_pcSrc", {31'b0, o_pcSrc}, 32'h0);
    check("rst_regWrite_MEM_WB", {31'b0, o_regWrite_MEM_WB}, 32'h0);
    i_reset = 1;

    doStore(32'h20, 32'h0, SZ_W);
    doStore(32'h30, 32'h0, SZ_W);
    doStore(32'h50, 32'h01020304, SZ_W);
    doStore(32'h60, 32'h12345678, SZ_W);

    doAlu(32'h12345678, 6'd5);
    check("exmem_rd", {26'b0, o_rd_EX_MEM}, 32'd5);
    check("exmem_regWrite", {31'b0, o_regWrite_EX_MEM}, 32'h1);
    check("exmem_alu", o_memData, 32'h12345678);
    nop();

    // Asynchronous reset in mid-cycle must clear outputs before the next edge.
    @(negedge i_clk);
    #1;
    i_reset = 0;
    #1;
    check("arst_wbData", o_wbData, 32'h0);
    check("arst_rd_MEM_WB", {26'b0, o_rd_MEM_WB}, 32'h0);
    check("arst_regWrite_MEM_WB", {31'b0, o_regWrite_MEM_WB}, 32'h0);
    check("arst_memData", o_memData, 32'h0);
    check("arst_regWrite_EX_MEM", {31'b0, o_regWrite_EX_MEM}, 32'h0);
    step();
    i_reset = 1;

    doStore(32'h50, 32'hCAFEF00D, SZ_W);
    #2;
    i_reset = 0;
    clearInputs();
    step();
    i_reset = 1;
    doLoad(32'h50, SZ_W, 0, 6'd6, 32'h01020304);

    doStore(32'h10, 32'hDEADBEEF, SZ_W);
    doLoad(32'h10, SZ_W, 0, 6'd1, 32'hDEADBEEF);

    doStore(32'h21, 32'hAAAAAA7F, SZ_B);
    doStore(32'h22, 32'h55555580, SZ_B);
    doLoad(32'h22, SZ_B, 0, 6'd2, 32'hFFFFFF80);
    doLoad(32'h22, SZ_B, 1, 6'd3, 32'h00000080);
    doLoad(32'h20, SZ_W, 0, 6'd4, 32'h00807F00);
    doLoad(32'h21, SZ_B, 0, 6'd8, 32'h0000007F);

    doStore(32'h32, 32'h55558001, SZ_H);
    doLoad(32'h32, SZ_H, 0, 6'd9, 32'hFFFF8001);
    doLoad(32'h32, SZ_H, 1, 6'd10, 32'h00008001);
    doLoad(32'h30, SZ_W, 0, 6'd11, 32'h80010000);
    doLoad(32'h30, SZ_H, 0, 6'd12, 32'h00000000);

    clearInputs();
    i_branch = 1; i_ceroSignal = 1; i_branchTarget = 32'h40;
    step();
    check("br_pcSrc", {31'b0, o_pcSrc}, 32'h1);
    check("br_target", o_branchTarget, 32'h40);
    i_ceroSignal = 0;
    step();
    check("br_nottaken", {31'b0, o_pcSrc}, 32'h0);

    clearInputs();
    i_branch = 1; i_ceroSignal = 1; i_branchTarget = 32'h80; i_flush = 1;
    i_memWrite = 1; i_aluResult = 32'h60; i_datoLeido2 = 32'hAAAAAAAA; i_regWrite = 1; i_rd = 6'd20;
    step();
    check("flush_pcSrc", {31'b0, o_pcSrc}, 32'h0);
    check("flush_target", o_branchTarget, 32'h80);
    check("flush_regWrite", {31'b0, o_regWrite_EX_MEM}, 32'h0);
    nop();
    doLoad(32'h60, SZ_W, 0, 6'd13, 32'h12345678);

    doAlu(32'h0BADF00D, 6'd7);
    doStore(32'h40, 32'h11223344, SZ_W);
    i_enable = 0;
    clearInputs();
    i_aluResult = 32'h44; i_memRead = 1; i_regWrite = 1; i_rd = 6'd14;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_memData", o_memData, 32'h40);
      check("stall_wbData", o_wbData, 32'h0BADF00D);
      check("stall_regWrite_EX_MEM", {31'b0, o_regWrite_EX_MEM}, 32'h0);
    end
    i_enable = 1;
    nop();
    doLoad(32'h40, SZ_W, 0, 6'd15, 32'h11223344);

`ifdef MEM_ALIGN_CHECK_EN
    doStore(32'h13, 32'hFFFFFFFF, SZ_W);
    check("misaligned_pulse", {31'b0, o_misaligned}, 32'h1);
    nop();
    check("misaligned_clear", {31'b0, o_misaligned}, 32'h0);
    doLoad(32'h10, SZ_W, 0, 6'd16, 32'hDEADBEEF);
    clearInputs();
    i_aluResult = 32'h13; i_memRead = 1; i_memToReg = 1; i_regWrite = 1; i_rd = 6'd17;
    step();
    nop();
    check("misaligned_regWrite", {31'b0, o_regWrite_MEM_WB}, 32'h0);
`else
    doLoad(32'h13, SZ_W, 0, 6'd16, 32'hDEADBEEF);
    doLoad(32'h33, SZ_H, 1, 6'd17, 32'h00008001);
`endif

    repeat (3) nop();
    check("sb_drained", sbQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
